morse_stream_decoder: RTL and testbench
=======================================

Name: morse_stream_decoder

Overview:
Sequential, parametrised Morse decoder. Accepts a stream of 2-bit Morse symbols over a valid/ready handshake and accumulates up to MAX_SYMBOLS per character. On a terminator it emits one ASCII byte over a valid/ready output handshake. Sits between the symbol timing classifier and the character sink (UART/display FIFO); handles word gaps, overflow and backpressure.

Parameters:
MAX_SYMBOLS, 5, max symbols per character (legal range 4..8); shift register width is 2*MAX_SYMBOLS.
UNKNOWN_CHAR, 8'd63, byte emitted for unmatched or overflowed codes ('?').

Ports:
Clock  in  1  single clock, rising edge.
Reset  in  1  synchronous, active-high.
SymValid  in  1  symbol present on SymCode.
SymCode  in  2  symbol: 2'b01 dot, 2'b11 dash, 2'b00 letter gap, 2'b10 word gap.
SymReady  out  1  decoder accepts a symbol this cycle.
CharValid  out  1  CharOut holds a valid byte.
CharOut  out  8  ASCII byte.
CharReady  in  1  sink accepts CharOut this cycle.
OverflowErr  out  1  one-cycle pulse when an overflowed character is emitted.

Behaviour:
- Reset: CharValid=0, CharOut=8'd0, OverflowErr=0, SymReady=1, symbol count=0, shift register=0, overflow flag=0, pending-space flag=0, last-emitted-space flag=1, state=IDLE.
- Reset mid-operation discards any partial character and any undelivered byte. No handshake completes in the reset cycle.
- A symbol transfer occurs when SymValid && SymReady. A character transfer occurs when CharValid && CharReady.
- SymReady = !CharValid. This is a registered-state decode with no combinational path from CharReady.
- Packing: the first symbol occupies the MSBs [2*MAX_SYMBOLS-1 -: 2]. Unused slots are 2'b00.
- States:
  - IDLE: count=0.
  - COLLECT: count>0.
  - EMIT: CharValid=1.
  - EMIT_SPACE: CharValid=1, CharOut=8'd32.
- Dot/dash:
  - If count<MAX_SYMBOLS, write the symbol into slot[count] and increment count.
  - Otherwise set the sticky overflow flag; count and register are held.
  - IDLE transitions to COLLECT.
- Letter gap:
  - count=0: ignored, no output.
  - count>0: the next cycle has CharValid=1 and CharOut=LUT(register), or UNKNOWN_CHAR if the overflow flag is set. Latency is 1 cycle. Count, register and overflow flag clear; state goes to EMIT.
- Word gap:
  - count>0: behaves as a letter gap and also sets the pending-space flag.
  - count=0: emits a space (EMIT_SPACE), unless last-emitted-space=1, in which case it is ignored.
- EMIT:
  - On a transfer, go to EMIT_SPACE if pending-space is set (clear the flag), else go to IDLE.
  - CharOut and CharValid are held stable while CharReady=0.
- EMIT_SPACE: on a transfer, go to IDLE and set last-emitted-space=1. Any non-space emit clears last-emitted-space.
- OverflowErr is high in the cycle an overflowed character transfers (CharValid && CharReady), otherwise 0.
- The LUT covers A–Z (65–90). Codes are left-aligned and zero-padded. Unmatched codes produce UNKNOWN_CHAR.

Optional Feature:
MORSE_DIGITS_EN:
- Defined: the LUT also decodes the five-symbol digits 0–9 to 48–57 (for example .---- gives 49, ----- gives 48). Requires MAX_SYMBOLS>=5; an elaboration error is raised otherwise.
- Undefined: five-symbol codes decode to UNKNOWN_CHAR. All other behaviour is identical.

Decomposition:
- Package morse_pkg holds:
  - symbol constants SYM_DOT, SYM_DASH, SYM_LGAP, SYM_WGAP;
  - ASCII constants ASCII_SPACE, ASCII_QMARK;
  - the state enum (IDLE, COLLECT, EMIT, EMIT_SPACE).
- Sub-module morse_lut: combinational, parametrised by MAX_SYMBOLS. Maps the packed register to ASCII or UNKNOWN_CHAR and contains the MORSE_DIGITS_EN entries. The top level owns the FSM, counter, flags and handshakes.

Test Plan:
1. Dot, dash, letter gap with CharReady=1: CharOut=65 and CharValid=1 exactly one cycle after the gap is accepted; then IDLE.
2. Dash, dot, dot, dot, word gap: CharOut=66, then 32 on the next transfer. A second word gap emits nothing. A third symbol sequence "." plus letter gap gives 69.
3. Six dots then a letter gap at MAX_SYMBOLS=5: CharOut=63 with OverflowErr pulsing for 1 cycle on transfer. A following "." plus letter gap gives 69 with OverflowErr=0.
4. Backpressure: the character 'T' is pending with CharReady=0 for 3 cycles. CharOut stays 84, CharValid stays 1, SymReady=0 and offered symbols are not consumed. Raise CharReady: transfer, then SymReady=1.
5. ".----" plus letter gap: 49 with MORSE_DIGITS_EN defined, 63 without. Repeated letter gaps in IDLE produce no output.
6. Assert Reset mid-character (after ".-") and in EMIT: all outputs return to reset values. Then "..." plus letter gap gives 83 with no residue.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: shared symbol codes, ASCII constants and FSM state type for the Morse decoder
package morse_pkg;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_LGAP = 2'b00;
  localparam logic [1:0] SYM_WGAP = 2'b10;
  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_QMARK = 8'd63;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, EMIT_SPACE} state_t;
endpackage

// File: rtl/morse_lut.sv
// morse_lut: left-aligned packed Morse code to ASCII; digits 0-9 added when MORSE_DIGITS_EN is defined
module morse_lut import morse_pkg::*; #(
  parameter int MAX_SYMBOLS = 5,
  parameter logic [7:0] UNKNOWN_CHAR = ASCII_QMARK
) (
  input  logic [2*MAX_SYMBOLS-1:0] code,
  output logic [7:0]               ascii
);
  if (MAX_SYMBOLS < 4 || MAX_SYMBOLS > 8) begin : g_range
    $error("morse_lut: MAX_SYMBOLS must be 4..8");
  end
`ifdef MORSE_DIGITS_EN
  if (MAX_SYMBOLS < 5) begin : g_digits
    $error("morse_lut: MORSE_DIGITS_EN needs MAX_SYMBOLS >= 5");
  end
`endif
  // Normalise to an 8-symbol field so the tables are independent of MAX_SYMBOLS.
  logic [15:0] c;
  assign c = 16'(code) << (16 - 2*MAX_SYMBOLS);
  always_comb begin
    ascii = UNKNOWN_CHAR;
    if (c[7:0] == 8'd0)
      case (c[15:8])
        8'b0111_0000: ascii = 8'd65;
        8'b1101_0101: ascii = 8'd66;
        8'b1101_1101: ascii = 8'd67;
        8'b1101_0100: ascii = 8'd68;
        8'b0100_0000: ascii = 8'd69;
        8'b0101_1101: ascii = 8'd70;
        8'b1111_0100: ascii = 8'd71;
        8'b0101_0101: ascii = 8'd72;
        8'b0101_0000: ascii = 8'd73;
        8'b0111_1111: ascii = 8'd74;
        8'b1101_1100: ascii = 8'd75;
        8'b0111_0101: ascii = 8'd76;
        8'b1111_0000: ascii = 8'd77;
        8'b1101_0000: ascii = 8'd78;
        8'b1111_1100: ascii = 8'd79;
        8'b0111_1101: ascii = 8'd80;
        8'b1111_0111: ascii = 8'd81;
        8'b0111_0100: ascii = 8'd82;
        8'b0101_0100: ascii = 8'd83;
        8'b1100_0000: ascii = 8'd84;
        8'b0101_1100: ascii = 8'd85;
        8'b0101_0111: ascii = 8'd86;
        8'b0111_1100: ascii = 8'd87;
        8'b1101_0111: ascii = 8'd88;
        8'b1101_1111: ascii = 8'd89;
        8'b1111_0101: ascii = 8'd90;
        default: ascii = UNKNOWN_CHAR;
      endcase
`ifdef MORSE_DIGITS_EN
    if (c[5:0] == 6'd0)
      case (c[15:6])
        10'b11_11_11_11_11: ascii = 8'd48;
        10'b01_11_11_11_11: ascii = 8'd49;
        10'b01_01_11_11_11: ascii = 8'd50;
        10'b01_01_01_11_11: ascii = 8'd51;
        10'b01_01_01_01_11: ascii = 8'd52;
        10'b01_01_01_01_01: ascii = 8'd53;
        10'b11_01_01_01_01: ascii = 8'd54;
        10'b11_11_01_01_01: ascii = 8'd55;
        10'b11_11_11_01_01: ascii = 8'd56;
        10'b11_11_11_11_01: ascii = 8'd57;
        default: ;
      endcase
`endif
  end
endmodule

// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: Morse symbol stream to ASCII bytes over valid/ready handshakes
// Optional digit decoding is enabled by defining MORSE_DIGITS_EN.
module morse_stream_decoder import morse_pkg::*; #(
  parameter int MAX_SYMBOLS = 5,
  parameter logic [7:0] UNKNOWN_CHAR = ASCII_QMARK
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SymValid,
  input  logic [1:0] SymCode,
  output logic       SymReady,
  output logic       CharValid,
  output logic [7:0] CharOut,
  input  logic       CharReady,
  output logic       OverflowErr
);
  localparam int CW = $clog2(MAX_SYMBOLS + 1);
  localparam int W = 2*MAX_SYMBOLS;
  localparam logic [CW-1:0] MAXC = CW'(MAX_SYMBOLS);
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [W-1:0] sr, sr_n;
  logic [7:0] char_q, char_n, lut_char;
  logic ovf, ovf_n, pend, pend_n, last_sp, last_sp_n, eovf, eovf_n;
  logic sym_xfer, chr_xfer;
  morse_lut #(.MAX_SYMBOLS(MAX_SYMBOLS), .UNKNOWN_CHAR(UNKNOWN_CHAR)) u_lut (.code(sr), .ascii(lut_char));
  assign CharValid = state == EMIT || state == EMIT_SPACE;
  assign SymReady = !CharValid;
  assign CharOut = char_q;
  assign OverflowErr = state == EMIT && CharReady && eovf;
  assign sym_xfer = SymValid && SymReady;
  assign chr_xfer = CharValid && CharReady;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      sr <= '0;
      ovf <= 1'b0;
      pend <= 1'b0;
      last_sp <= 1'b1;
      char_q <= 8'd0;
      eovf <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      sr <= sr_n;
      ovf <= ovf_n;
      pend <= pend_n;
      last_sp <= last_sp_n;
      char_q <= char_n;
      eovf <= eovf_n;
    end
  end
  always_comb begin
    state_n = state;
    count_n = count;
    sr_n = sr;
    ovf_n = ovf;
    pend_n = pend;
    last_sp_n = last_sp;
    char_n = char_q;
    eovf_n = eovf;
    case (state)
      IDLE, COLLECT: if (sym_xfer) begin
        if (SymCode == SYM_DOT || SymCode == SYM_DASH) begin
          // Slot[count] counted from the MSB end; extra symbols only mark overflow.
          if (count < MAXC) begin
            sr_n = sr | ({SymCode, {(W-2){1'b0}}} >> {count, 1'b0});
            count_n = count + CW'(1);
          end else ovf_n = 1'b1;
          state_n = COLLECT;
        end else if (count != '0) begin
          char_n = ovf ? UNKNOWN_CHAR : lut_char;
          eovf_n = ovf;
          count_n = '0;
          sr_n = '0;
          ovf_n = 1'b0;
          pend_n = SymCode == SYM_WGAP;
          state_n = EMIT;
        end else if (SymCode != SYM_LGAP && !last_sp) begin
          char_n = ASCII_SPACE;
          state_n = EMIT_SPACE;
        end
      end
      EMIT: if (chr_xfer) begin
        last_sp_n = 1'b0;
        eovf_n = 1'b0;
        pend_n = 1'b0;
        char_n = pend ? ASCII_SPACE : char_q;
        state_n = pend ? EMIT_SPACE : IDLE;
      end
      EMIT_SPACE: if (chr_xfer) begin
        last_sp_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder: directed table, hand sequences and randomized stream against a string-level Morse model
module tb_morse_stream_decoder;
  import morse_pkg::*;
  localparam int MAX = 5;
  logic Clock = 0, Reset = 1, SymValid = 0, CharReady = 1;
  logic [1:0] SymCode = 2'b00;
  logic SymReady, CharValid, OverflowErr;
  logic [7:0] CharOut;
  int vectors = 0, miscompares = 0;
  logic [8:0] got_q[$], exp_q[$];
  bit rnd_rdy = 0, prev_stall = 0, mlast = 1;
  logic [7:0] prev_out;
  string cur = "";
  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
  typedef struct { string syms; string exp; int novf; } vec_t;
  vec_t tbl[$];

  morse_stream_decoder #(.MAX_SYMBOLS(MAX), .UNKNOWN_CHAR(8'd63)) dut (
    .Clock(Clock), .Reset(Reset), .SymValid(SymValid), .SymCode(SymCode), .SymReady(SymReady),
    .CharValid(CharValid), .CharOut(CharOut), .CharReady(CharReady), .OverflowErr(OverflowErr));

  always #5 Clock = ~Clock;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  function automatic logic [7:0] lookup(string s);
    for (int i = 0; i < 26; i++) if (s == letters[i]) return 8'(65 + i);
`ifdef MORSE_DIGITS_EN
    for (int i = 0; i < 10; i++) if (s == digits[i]) return 8'(48 + i);
`endif
    return 8'd63;
  endfunction

  // Character-level reference: accumulate symbol text, decode whole characters on gaps.
  function automatic void model_sym(logic [1:0] c);
    if (c == SYM_DOT) cur = {cur, "."};
    else if (c == SYM_DASH) cur = {cur, "-"};
    else begin
      if (cur.len() > 0) begin
        exp_q.push_back(cur.len() > MAX ? {1'b1, 8'd63} : {1'b0, lookup(cur)});
        mlast = 0;
        cur = "";
      end
      if (c == SYM_WGAP && !mlast) begin
        exp_q.push_back({1'b0, 8'd32});
        mlast = 1;
      end
    end
  endfunction

  always @(negedge Clock) begin
    if (Reset) prev_stall = 0;
    else begin
      chk("symready_decode", SymReady, !CharValid);
      if (prev_stall) begin
        chk("hold_valid", CharValid, 1);
        chk("hold_out", CharOut, prev_out);
      end
      if (CharValid && CharReady) got_q.push_back({OverflowErr, CharOut});
      else chk("ovf_no_xfer", OverflowErr, 0);
      prev_stall = CharValid && !CharReady;
      prev_out = CharOut;
    end
  end

  always @(posedge Clock) begin
    #1;
    if (rnd_rdy) CharReady = ($urandom_range(0, 3) != 0);
  end

  task automatic do_reset();
    Reset = 1;
    SymValid = 0;
    @(posedge Clock);
    @(negedge Clock);
    chk("rst_valid", CharValid, 0);
    chk("rst_out", CharOut, 0);
    chk("rst_ovf", OverflowErr, 0);
    chk("rst_symready", SymReady, 1);
    @(posedge Clock);
    #1 Reset = 0;
    cur = "";
    mlast = 1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_sym(logic [1:0] c);
    int n = 0;
    SymValid = 1;
    SymCode = c;
    @(negedge Clock);
    while (!SymReady && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) chk("sym_accept_timeout", n, 0);
    @(posedge Clock);
    #1 SymValid = 0;
    model_sym(c);
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++)
      send_sym(s[i] == "." ? SYM_DOT : s[i] == "-" ? SYM_DASH : s[i] == "/" ? SYM_LGAP : SYM_WGAP);
  endtask

  task automatic drain();
    rnd_rdy = 0;
    repeat (8) begin
      @(posedge Clock);
      #1 CharReady = 1;
    end
  endtask

  initial begin
    string d0, d1, d5, r;
    int novf;
`ifdef MORSE_DIGITS_EN
    d0 = "0"; d1 = "1"; d5 = "5";
`else
    d0 = "?"; d1 = "?"; d5 = "?";
`endif
    tbl.push_back('{"_", "", 0});
    tbl.push_back('{".-/", "A", 0});
    tbl.push_back('{"-..._", "B ", 0});
    tbl.push_back('{"_", "", 0});
    tbl.push_back('{"./", "E", 0});
    tbl.push_back('{"....../", "?", 1});
    tbl.push_back('{"./", "E", 0});
    tbl.push_back('{"///", "", 0});
    tbl.push_back('{".----/", d1, 0});
    tbl.push_back('{"-----_", {d0, " "}, 0});
    tbl.push_back('{"--../.--./-.--/", "ZPY", 0});
    tbl.push_back('{"-.-.--.-/", "?", 1});
    tbl.push_back('{"...._/", "H ", 0});
    tbl.push_back('{"-_._", "T E ", 0});
    tbl.push_back('{"...../", d5, 0});

    do_reset();
    // 'A' must be visible exactly one cycle after the gap is taken.
    send_str(".-/");
    @(negedge Clock);
    chk("lat_valid", CharValid, 1);
    chk("lat_out", CharOut, 65);
    @(posedge Clock);
    @(negedge Clock);
    chk("lat_idle_valid", CharValid, 0);
    chk("lat_idle_ready", SymReady, 1);
    @(posedge Clock);
    #1;

    do_reset();
    foreach (tbl[v]) begin
      got_q.delete();
      send_str(tbl[v].syms);
      drain();
      chk($sformatf("vec%0d_len", v), got_q.size(), tbl[v].exp.len());
      novf = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        novf += got_q[i][8];
        if (i < tbl[v].exp.len()) chk($sformatf("vec%0d_char%0d", v, i), got_q[i][7:0], tbl[v].exp[i]);
      end
      chk($sformatf("vec%0d_ovf", v), novf, tbl[v].novf);
    end

    // Backpressure: 'T' held while the sink stalls, offered dot must not be taken.
    got_q.delete();
    CharReady = 0;
    send_str("-/");
    SymValid = 1;
    SymCode = SYM_DOT;
    repeat (3) begin
      @(negedge Clock);
      chk("bp_valid", CharValid, 1);
      chk("bp_out", CharOut, 84);
      chk("bp_symready", SymReady, 0);
      @(posedge Clock);
      #1;
    end
    SymValid = 0;
    CharReady = 1;
    @(posedge Clock);
    @(negedge Clock);
    chk("bp_release_ready", SymReady, 1);
    @(posedge Clock);
    #1;
    chk("bp_count", got_q.size(), 1);
    chk("bp_char", got_q.size() > 0 ? got_q[0] : 9'h1ff, {1'b0, 8'd84});
    got_q.delete();
    send_str("./");
    drain();
    chk("bp_nodot_count", got_q.size(), 1);
    chk("bp_nodot_char", got_q.size() > 0 ? got_q[0] : 9'h1ff, {1'b0, 8'd69});

    // Reset mid-character and while a byte is stalled in EMIT.
    do_reset();
    send_str(".-");
    do_reset();
    CharReady = 0;
    send_str("-/");
    @(negedge Clock);
    chk("rst_emit_pending", CharValid, 1);
    @(posedge Clock);
    #1;
    do_reset();
    CharReady = 1;
    send_str(".../");
    drain();
    chk("rst_residue_count", got_q.size(), 1);
    chk("rst_residue_char", got_q.size() > 0 ? got_q[0] : 9'h1ff, {1'b0, 8'd83});

    do_reset();
    rnd_rdy = 1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: r = letters[$urandom_range(0, 25)];
        6: r = digits[$urandom_range(0, 9)];
        default: begin
          r = "";
          repeat ($urandom_range(0, 7)) if ($urandom_range(0, 1) != 0) r = {r, "."}; else r = {r, "-"};
        end
      endcase
      r = {r, ($urandom_range(0, 3) == 0) ? "_" : "/"};
      if ($urandom_range(0, 7) == 0) r = {r, "_"};
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clock);
        #1;
      end
      send_str(r);
    end
    drain();
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("rnd_char%0d", i), got_q[i], exp_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
